pool_vector_builder: RTL
========================

# pool_vector_builder

Upstream stage of the fully-connected neuron. Accepts a serial stream of 8-bit unsigned pixels and max-pools every POOL_W consecutive pixels into one value. Packs NUM_OUT pooled values into an array and presents it on a valid/ready output whose data port matches the neuron's `[7:0][7:0]` pooled-pixel input. Uses a separate assembly buffer and output register, so the next vector can be built while the current one is held.

## Interface
- POOL_W, 2: pixels per pooling window (≥1).
- NUM_OUT, 8: pooled values per output vector (≥1).
- PIX_W, 8: pixel width in bits.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_pixel/in_last valid.
- in_ready  out  1  block accepts the input this cycle.
- in_pixel  in  PIX_W  unsigned pixel.
- in_last  in  1  final pixel of the frame; closes the current window and vector early.
- out_valid  out  1  pooled_array/out_count valid.
- out_ready  in  1  consumer accepts the output this cycle.
- pooled_array  out  [NUM_OUT-1:0][PIX_W-1:0]  pooled values; slot 0 holds the first window.
- out_count  out  $clog2(NUM_OUT+1)  number of meaningful slots (1..NUM_OUT).

## Operation
- Accept condition: in_valid && in_ready.
- State registers:
  - win_max (PIX_W): running maximum.
  - win_cnt (0..POOL_W-1): pixels in the current window.
  - slot_cnt (0..NUM_OUT-1): next assembly slot.
  - asm_buf [NUM_OUT][PIX_W]: assembly buffer.
  - Output register: pooled_array, out_count, out_valid.
- Window max, per accepted pixel p:
  - cur = p if win_cnt==0, else max(win_max, p).
  - Comparison is unsigned; equal values give that value.
- Window closes when win_cnt==POOL_W-1 or in_last. On close:
  - Write cur to asm_buf[slot_cnt].
  - Set win_cnt to 0.
  - Otherwise win_max<=cur and win_cnt increments.
- Vector closes when a window closes with slot_cnt==NUM_OUT-1, or on in_last. On vector close:
  - pooled_array <= asm_buf with slot slot_cnt replaced by cur; slots above slot_cnt are forced to 0.
  - out_count <= slot_cnt+1.
  - out_valid <= 1.
  - slot_cnt <= 0 and asm_buf is cleared to 0.
- in_last partial window: the pooled value is the max of only the pixels received (e.g. one pixel, so the value is that pixel).
- out_free = !out_valid || out_ready.
- closing = slot_cnt==NUM_OUT-1 && win_cnt==POOL_W-1.
- in_ready = out_free || (!closing && !in_last).
  - Ready depends combinationally on in_last and out_ready only, not on in_valid.
  - Input stalls only on a vector-closing pixel while the output is held.
- Output handshake: when out_valid && out_ready, out_valid drops next cycle unless a new vector closes in the same cycle, in which case it stays 1 with the new data.
- Output stability: while out_valid && !out_ready, pooled_array and out_count hold stable.
- Overflow: cannot occur; arithmetic is compare-only.

## Timing
- Reset (rst_n low, asynchronous), all outputs and state cleared:
  - out_valid=0, pooled_array=0, out_count=0.
  - win_cnt=0, slot_cnt=0, win_max=0, asm_buf=0.
  - in_ready is forced 0 while rst_n is low and is 1 in the first cycle after release.
- Reset mid-vector discards the partial window, partial vector and any held output. There is no flush.
- Latency: out_valid rises on the clock edge that accepts the vector-closing pixel, so data is visible the cycle after acceptance.
- Throughput: one pixel per cycle sustained while out_ready=1. One full vector every POOL_W·NUM_OUT cycles with no bubbles.
- Backpressure: out_valid may stay high indefinitely. Non-closing pixels keep being accepted into asm_buf meanwhile.
- Consumer sampling: the FC neuron samples pooled_array on the output handshake, and the pooled data is stable from that edge.

## Test plan
- Defaults, pixels 0..15 streamed, out_ready=1 → one output, pooled_array={1,3,5,7,9,11,13,15}, out_count=8, out_valid high exactly 1 cycle after the 16th accept.
- Pixels {9,2,7,7,4} with in_last on 4 → pooled_array={9,7,4,0,0,0,0,0}, out_count=3. The next frame starts at slot 0 with win_cnt 0.
- out_ready=0 after the first vector, continuous 32-pixel stream → in_ready drops only on pixel 32 and the first vector holds stable. Raising out_ready delivers vector 1, and pixel 32 is accepted that same cycle. Vector 2 is valid next cycle with no pixel lost.
- Descending/equal values {255,0,0,255,128,128,...}, back-to-back vectors with out_ready=1 → out_valid stays continuously high across vectors with correct max per window (255,255,128,...).
- rst_n pulsed low after 5 pixels while a previous output is held → out_valid=0 immediately. A following 16-pixel stream yields a vector containing none of the pre-reset pixels.
- POOL_W=1, NUM_OUT=8 → pooled_array equals the raw input pixels in order. in_last on the first pixel gives out_count=1.

Source files
------------

// File: rtl/pool_vector_builder_if.sv
// ---------------------------------------------------------------------------
// pool_vector_builder_if
//   Bundles the pixel input stream and the pooled-vector output stream of
//   pool_vector_builder.
//
//   Handshake rule for both streams: a transfer happens on a rising clk edge
//   where valid && ready are both 1. The producer holds its valid and data
//   stable until that transfer. ready may depend on the producer's in_last
//   but never on its valid.
//
//   Signals
//     in_valid      pixel/in_last valid (producer -> block)
//     in_ready      block accepts the pixel this cycle
//     in_pixel      unsigned pixel
//     in_last       final pixel of the frame
//     out_valid     pooled_array/out_count valid (block -> consumer)
//     out_ready     consumer accepts the vector this cycle
//     pooled_array  pooled values, slot 0 = first window
//     out_count     number of meaningful slots (1..NUM_OUT)
//
//   Modports
//     master  the side that feeds pixels in and consumes vectors
//     slave   the pool_vector_builder block itself
// ---------------------------------------------------------------------------
interface pool_vector_builder_if #(
    parameter int NUM_OUT = 8,
    parameter int PIX_W   = 8,
    parameter int CNT_W   = $clog2(NUM_OUT + 1)
) ();
    logic                             in_valid;
    logic                             in_ready;
    logic [PIX_W-1:0]                 in_pixel;
    logic                             in_last;
    logic                             out_valid;
    logic                             out_ready;
    logic [NUM_OUT-1:0][PIX_W-1:0]    pooled_array;
    logic [CNT_W-1:0]                 out_count;

    modport master (
        output in_valid, in_pixel, in_last, out_ready,
        input  in_ready, out_valid, pooled_array, out_count
    );

    modport slave (
        input  in_valid, in_pixel, in_last, out_ready,
        output in_ready, out_valid, pooled_array, out_count
    );
endinterface

// File: rtl/pool_vector_builder.sv
// ---------------------------------------------------------------------------
// pool_vector_builder
//   Max-pools every POOL_W consecutive unsigned pixels into one value and
//   packs NUM_OUT pooled values into a vector. A frame-final pixel (in_last)
//   closes both the current window and the current vector early. Vectors are
//   built in an assembly buffer and copied into a separate output register,
//   so the next vector can be assembled while the previous one is held.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    pool_vector_builder_if.slave (pixel in, vector out)
// ---------------------------------------------------------------------------
module pool_vector_builder #(
    parameter int POOL_W  = 2,
    parameter int NUM_OUT = 8,
    parameter int PIX_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pool_vector_builder_if.slave  bus
);
    localparam int CNT_W = $clog2(NUM_OUT + 1);
    localparam int WC_W  = (POOL_W  > 1) ? $clog2(POOL_W)  : 1;
    localparam int SL_W  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    logic [PIX_W-1:0]              win_max;
    logic [WC_W-1:0]               win_cnt;
    logic [SL_W-1:0]               slot_cnt;
    logic [NUM_OUT-1:0][PIX_W-1:0] asm_buf;

    logic                          out_valid_q;
    logic [NUM_OUT-1:0][PIX_W-1:0] out_arr_q;
    logic [CNT_W-1:0]              out_cnt_q;

    logic                          win_last;
    logic                          slot_last;
    logic                          out_free;
    logic                          closing;
    logic                          in_ready_c;
    logic                          accept;
    logic                          win_close;
    logic                          vec_close;
    logic [PIX_W-1:0]              cur;
    logic [NUM_OUT-1:0][PIX_W-1:0] next_vec;

    assign win_last  = (win_cnt  == WC_W'(POOL_W - 1));
    assign slot_last = (slot_cnt == SL_W'(NUM_OUT - 1));

    // The output register can take a new vector if it is empty or being
    // drained this very cycle.
    assign out_free  = !out_valid_q || bus.out_ready;

    // Only a pixel that would close a vector needs the output register, so
    // only such a pixel (full vector or in_last) can be stalled. Ready is
    // held low while reset is asserted.
    assign closing    = slot_last && win_last;
    assign in_ready_c = rst_n && (out_free || (!closing && !bus.in_last));

    assign accept    = bus.in_valid && in_ready_c;
    assign win_close = win_last || bus.in_last;
    assign vec_close = win_close && (slot_last || bus.in_last);

    // First pixel of a window starts the max afresh; ties keep the value.
    assign cur = (win_cnt == '0) ? bus.in_pixel
               : ((bus.in_pixel > win_max) ? bus.in_pixel : win_max);

    // Vector as it will be presented: filled slots, the closing value in
    // the current slot, zeros above it.
    always_comb begin
        next_vec = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (i < int'(slot_cnt)) begin
                next_vec[i] = asm_buf[i];
            end else if (i == int'(slot_cnt)) begin
                next_vec[i] = cur;
            end
        end
    end

    // Window and assembly state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_max  <= '0;
            win_cnt  <= '0;
            slot_cnt <= '0;
            asm_buf  <= '0;
        end else if (accept) begin
            if (win_close) begin
                win_cnt <= '0;
                if (vec_close) begin
                    slot_cnt <= '0;
                    asm_buf  <= '0;
                end else begin
                    asm_buf[slot_cnt] <= cur;
                    slot_cnt          <= slot_cnt + SL_W'(1);
                end
            end else begin
                win_max <= cur;
                win_cnt <= win_cnt + WC_W'(1);
            end
        end
    end

    // Output register. A vector closing in the same cycle as a drain
    // replaces the drained one, keeping out_valid high without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_arr_q   <= '0;
            out_cnt_q   <= '0;
        end else if (accept && vec_close) begin
            out_valid_q <= 1'b1;
            out_arr_q   <= next_vec;
            out_cnt_q   <= CNT_W'(slot_cnt) + CNT_W'(1);
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready     = in_ready_c;
    assign bus.out_valid    = out_valid_q;
    assign bus.pooled_array = out_arr_q;
    assign bus.out_count    = out_cnt_q;

endmodule
